dmem_responder: RTL and testbench

- Memory-side responder for the MIPS CPU's data-memory port.
- Accepts one load/store request at a time over a valid/ready request channel and inserts a fixed number of wait states.
- Returns read data and an error flag over a valid/ready response channel.
- Sits between the CPU load/store stage and word-organised storage, so the CPU can be exercised against non-zero memory latency.

---
 rtl/mips_mem_pkg.sv | 21 ++
 rtl/dmem_array.sv | 36 +++
 rtl/dmem_responder.sv | 165 ++++++++++++++++
 tb/tb_dmem_responder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared definitions for the MIPS data-memory path.
//   - state_t        : responder FSM states (IDLE, WAIT, RESP)
//   - WORD_W/BYTE_W  : word and byte-lane widths
//   - word_index()   : byte address -> word index (drops the byte offset)
package mips_mem_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_W     = 8;
    localparam int BYTE_LANES = WORD_W / BYTE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [29:0] word_index(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-organised storage, synchronous write with per-byte
// enables, combinational read. Contents are not reset.
// Ports:
//   clk    - write clock (rising edge)
//   addr   - word index, shared by read and write
//   we     - write strobe
//   be     - byte-lane enables for the write
//   wdata  - write word
//   rdata  - word currently at addr
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic                  clk,
    input  logic [AW-1:0]         addr,
    input  logic                  we,
    input  logic [BYTE_LANES-1:0] be,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (we && be[i]) begin
                mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the CPU data-memory port.
// Accepts one load/store at a time, waits WAIT_CYCLES, then returns
// read data and an error flag.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; the sender holds its payload stable while valid is high and
// ready is low, and ready never depends combinationally on valid.
//
// Ports:
//   clk, rst                 - clock; asynchronous active-low reset
//   req_valid/req_ready      - request channel
//   req_we, req_addr,
//   req_wdata, req_be        - request payload (store flag, byte address,
//                              store data, byte enables)
//   resp_valid/resp_ready    - response channel
//   resp_rdata, resp_err     - load data (0 for stores/errors), error flag
//   dbg_state                - current FSM state, for observation only
//
// Build option: define DMEM_BYTE_WRITE_EN to honour req_be per byte;
// otherwise every store writes the whole word.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output state_t      dbg_state
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        do_access;
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_be;
    logic [3:0]  be_eff;
    logic [29:0] word_idx;
    logic        acc_err;
    logic        mem_we;
    logic [31:0] mem_rdata;

    assign accept = (state == IDLE) && req_valid;

    // With zero wait states the access happens on the accept edge, so the
    // live request feeds the datapath in IDLE; otherwise the latched copy.
    assign cur_we    = (state == IDLE) ? req_we    : lat_we;
    assign cur_addr  = (state == IDLE) ? req_addr  : lat_addr;
    assign cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign cur_be    = (state == IDLE) ? req_be    : lat_be;

    assign word_idx = word_index(cur_addr);
    assign acc_err  = (cur_addr[1:0] != 2'b00) || (word_idx >= 30'(DEPTH_WORDS));

`ifdef DMEM_BYTE_WRITE_EN
    assign be_eff = cur_be;
`else
    assign be_eff = 4'hF;
`endif

    // rst gates the write so nothing can commit while reset is held.
    assign mem_we = do_access && cur_we && !acc_err && rst;

    always_comb begin
        state_nx  = state;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        do_access = 1'b1;
                        state_nx  = RESP;
                    end else begin
                        state_nx  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    do_access = 1'b1;
                    state_nx  = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
                cnt       <= CNT_LOAD;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access) begin
                rdata_q <= (cur_we || acc_err) ? 32'd0 : mem_rdata;
                err_q   <= acc_err;
            end else if (state == RESP && resp_ready) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b0;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .addr (word_idx[AW-1:0]),
        .we   (mem_we),
        .be   (be_eff),
        .wdata(cur_wdata),
        .rdata(mem_rdata)
    );

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a word-array reference model, a per-cycle
// compare process, directed scenarios with literal expectations and a
// randomized phase. A second instance runs with zero wait states.
module tb_dmem_responder;
  import mips_mem_pkg::*;

  localparam int DEPTH = 256;
  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  state_t      dbg_state;

  logic        d0_req_valid = 1'b0;
  logic        d0_req_ready;
  logic        d0_req_we = 1'b0;
  logic [31:0] d0_req_addr = '0;
  logic [31:0] d0_req_wdata = '0;
  logic [3:0]  d0_req_be = '0;
  logic        d0_resp_valid;
  logic        d0_resp_ready = 1'b1;
  logic [31:0] d0_resp_rdata;
  logic        d0_resp_err;
  state_t      d0_dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state(dbg_state)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(d0_req_valid), .req_ready(d0_req_ready), .req_we(d0_req_we),
    .req_addr(d0_req_addr), .req_wdata(d0_req_wdata), .req_be(d0_req_be),
    .resp_valid(d0_resp_valid), .resp_ready(d0_resp_ready),
    .resp_rdata(d0_resp_rdata), .resp_err(d0_resp_err), .dbg_state(d0_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err = 0;

  // entry = {accept cycle, err, rdata}
  logic [64:0] exp_q[$];
  logic [31:0] mdl_mem[DEPTH];
  bit chk_en = 1'b0;
  bit hs_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the effect of one transaction on a plain word array.
  task automatic model_apply(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, output logic [31:0] rd, output bit er);
    logic [31:0] mask;
    logic [3:0]  eff;
    int          idx;
    idx = int'(addr / 4);
    er  = (addr % 4 != 0) || (addr / 4 >= DEPTH);
    rd  = 32'd0;
`ifdef DMEM_BYTE_WRITE_EN
    eff = be;
`else
    eff = 4'hF;
`endif
    if (!er) begin
      if (we) begin
        mask = 32'd0;
        for (int i = 0; i < 4; i++) if (eff[i]) mask = mask | (32'hFF << (8 * i));
        mdl_mem[idx] = (mdl_mem[idx] & ~mask) | (wdata & mask);
      end else begin
        rd = mdl_mem[idx];
      end
    end
  endtask

  // Per-cycle compare: idle when nothing outstanding; otherwise response
  // must appear exactly WAITC edges after accept and stay stable.
  always @(negedge clk) begin
    logic [64:0] e;
    int          el;
    bit          exp_v;
    if (chk_en && rst) begin
      if (hs_prev && exp_q.size() > 0) void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("idle_resp_valid", 32'(resp_valid), 32'd0);
      end else begin
        e = exp_q[0];
        el = cyc - int'(e[64:33]);
        exp_v = (el >= WAITC);
        chk("resp_valid_timing", 32'(resp_valid), 32'(exp_v));
        chk("busy_req_ready", 32'(req_ready), 32'd0);
        if (exp_v && resp_valid) begin
          chk("resp_rdata", resp_rdata, e[31:0]);
          chk("resp_err", 32'(resp_err), 32'(e[32]));
        end
      end
      hs_prev = resp_valid && resp_ready;
    end else begin
      hs_prev = 1'b0;
    end
  end

  // ---------------- resp_ready driver ----------------
  bit rr_force = 1'b1;
  bit rr_val = 1'b1;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_force) resp_ready = rr_val;
      else resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be);
    logic [31:0] rd;
    bit          er;
    int          n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = $urandom_range(0, 1);
    req_addr  = $urandom();
    req_wdata = $urandom();
    model_apply(we, addr, wdata, be, rd, er);
    exp_q.push_back({32'(cyc), er, rd});
  endtask

  task automatic wait_resp(output logic [31:0] rd, output bit er);
    int n;
    n = 0;
    rd = 'x;
    er = 1'bx;
    @(negedge clk);
    while (!(resp_valid && resp_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("resp_timeout", 32'(resp_valid && resp_ready), 32'd1);
    rd = resp_rdata;
    er = resp_err;
    @(posedge clk);
  endtask

  task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rd, output bit er);
    send_req(we, addr, wdata, be);
    wait_resp(rd, er);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd;
    bit          er;
    logic [31:0] a;
    int          n;

    // reset held for 2 cycles
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk_en = 1'b1;

    // give every word a known value
    for (int i = 0; i < DEPTH; i++) do_txn(1'b1, 32'(i * 4), $urandom(), 4'hF, rd, er);

    // store then load with literal latency and data
    send_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clk); chk("lat_store_e1", 32'(resp_valid), 32'd0);
    @(negedge clk); chk("lat_store_e2", 32'(resp_valid), 32'd0);
    @(negedge clk); chk("lat_store_e3", 32'(resp_valid), 32'd1);
    chk("store_err", 32'(resp_err), 32'd0);
    chk("store_rdata", resp_rdata, 32'd0);
    @(posedge clk);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er);
    chk("load_back", rd, 32'hDEADBEEF);

    // partial byte store
    do_txn(1'b1, 32'h10, 32'h00000055, 4'b0001, rd, er);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er);
`ifdef DMEM_BYTE_WRITE_EN
    chk("byte_store", rd, 32'hDEADBE55);
`else
    chk("byte_store", rd, 32'h00000055);
`endif

    // errors
    do_txn(1'b0, 32'h13, 32'h0, 4'h0, rd, er);
    chk("misaligned_err", 32'(er), 32'd1);
    chk("misaligned_rdata", rd, 32'd0);
    do_txn(1'b1, 32'h0, 32'hA5A50F0F, 4'hF, rd, er);
    do_txn(1'b1, 32'h400, 32'h11111111, 4'hF, rd, er);
    chk("range_err", 32'(er), 32'd1);
    do_txn(1'b0, 32'h0, 32'h0, 4'h0, rd, er);
    chk("range_no_write", rd, 32'hA5A50F0F);
    chk("range_no_write_err", 32'(er), 32'd0);

    // backpressure: hold resp_ready low 5 cycles while valid
    rr_val = 1'b0;
    @(posedge clk);
    send_req(1'b0, 32'h10, 32'h0, 4'h0);
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp_valid_seen", 32'(resp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(resp_valid), 32'd1);
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    rr_val = 1'b1;
    wait_resp(rd, er);
`ifdef DMEM_BYTE_WRITE_EN
    chk("bp_rdata", rd, 32'hDEADBE55);
`else
    chk("bp_rdata", rd, 32'h00000055);
`endif

    // reset in WAIT during a store: the store must not land
    do_txn(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, rd, er);
    @(negedge clk);
    chk_en = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
    req_wdata = 32'h12345678; req_be = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("abort_in_wait", 32'(dbg_state), 32'(WAIT));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_rdata", resp_rdata, 32'd0);
    chk("abort_state", 32'(dbg_state), 32'(IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    chk_en = 1'b1;
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er);
    chk("abort_no_write", rd, 32'hCAFEF00D);

    // zero-wait-state instance
    @(negedge clk);
    d0_req_valid = 1'b1; d0_req_we = 1'b1; d0_req_addr = 32'h8;
    d0_req_wdata = 32'h13579BDF; d0_req_be = 4'hF;
    @(posedge clk);
    #1;
    d0_req_valid = 1'b0;
    @(negedge clk);
    chk("w0_store_valid", 32'(d0_resp_valid), 32'd1);
    chk("w0_store_err", 32'(d0_resp_err), 32'd0);
    chk("w0_busy_ready", 32'(d0_req_ready), 32'd0);
    @(negedge clk);
    chk("w0_drop_valid", 32'(d0_resp_valid), 32'd0);
    chk("w0_ready_back", 32'(d0_req_ready), 32'd1);
    d0_req_valid = 1'b1; d0_req_we = 1'b0; d0_req_addr = 32'h8;
    @(posedge clk);
    #1;
    d0_req_valid = 1'b0;
    @(negedge clk);
    chk("w0_load_valid", 32'(d0_resp_valid), 32'd1);
    chk("w0_load_rdata", d0_resp_rdata, 32'h13579BDF);

    // randomized traffic with random response backpressure
    rr_force = 1'b0;
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 9))
        0: a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        1: a = 32'h400 + (32'($urandom_range(0, 4000)) << 2);
        2: a = $urandom() | 32'h8000_0000;
        default: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      endcase
      do_txn(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)), rd, er);
    end
    rr_force = 1'b1;
    rr_val = 1'b1;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
